// File: rtl/gw_config_pkg.sv
// Shared layout of the game config header image: field offsets, the config
// snapshot struct and the byte-level image builder used by uploader and loader.
package gw_config_pkg;

  localparam logic [24:0] IMAGE_START_ADDR = 25'h0000000;
  localparam logic [24:0] IMAGE_END_ADDR   = 25'h000007F;
  localparam logic [7:0]  HEADER_VERSION   = 8'h01;

  localparam logic [7:0] VERSION_BYTE     = 8'd0;
  localparam logic [7:0] MPU_BYTE         = 8'd1;
  localparam logic [7:0] SCREEN_CFG_BYTE  = 8'd2;
  localparam logic [7:0] SCREEN_SIZE_BYTE = 8'd3;
  localparam logic [7:0] RESERVED_BYTE    = 8'd6;
  localparam logic [7:0] INPUT_MAP_BYTE   = 8'd8;
  localparam logic [7:0] INPUT_B_BYTE     = 8'd40;
  localparam logic [7:0] INPUT_BA_BYTE    = 8'd41;
  localparam logic [7:0] INPUT_ACL_BYTE   = 8'd42;

  localparam logic [15:0] TIMEOUT_WORD = 16'hDEAD;

  typedef struct packed {
    logic [7:0]       mpu;
    logic [7:0]       screen_config;
    logic [11:0]      screen_width;
    logic [11:0]      screen_height;
    logic [7:0][31:0] input_s;
    logic [7:0]       input_b;
    logic [7:0]       input_ba;
    logic [7:0]       input_acl;
  } game_config_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HDR      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } upload_state_e;

  // Byte idx of the header image; everything not listed reads as zero.
  function automatic logic [7:0] header_byte(input game_config_t cfg, input logic [7:0] idx);
    logic [23:0] size;
    logic [7:0]  rel;
    logic [31:0] map_word;
    size     = {cfg.screen_height, cfg.screen_width};
    rel      = idx - INPUT_MAP_BYTE;
    map_word = cfg.input_s[rel[4:2]];
    header_byte = 8'h00;
    if (idx == VERSION_BYTE) begin
      header_byte = HEADER_VERSION;
    end else if (idx == MPU_BYTE) begin
      header_byte = cfg.mpu;
    end else if (idx == SCREEN_CFG_BYTE) begin
      header_byte = cfg.screen_config;
    end else if (idx == SCREEN_SIZE_BYTE) begin
      header_byte = size[7:0];
    end else if (idx == SCREEN_SIZE_BYTE + 8'd1) begin
      header_byte = size[15:8];
    end else if (idx == SCREEN_SIZE_BYTE + 8'd2) begin
      header_byte = size[23:16];
    end else if (idx >= INPUT_MAP_BYTE && idx < INPUT_B_BYTE) begin
      header_byte = map_word[{rel[1:0], 3'b000} +: 8];
    end else if (idx == INPUT_B_BYTE) begin
      header_byte = cfg.input_b;
    end else if (idx == INPUT_BA_BYTE) begin
      header_byte = cfg.input_ba;
    end else if (idx == INPUT_ACL_BYTE) begin
      header_byte = cfg.input_acl;
    end
  endfunction

endpackage

// File: rtl/config_header_rom.sv
// Combinational header image: maps a word address to {byte 2n+1, byte 2n}
// of the config snapshot.
module config_header_rom
  import gw_config_pkg::*;
(
  input  game_config_t cfg_i,
  input  logic [6:0]   word_addr_i,
  output logic [15:0]  word_o
);

  always_comb begin
    word_o = {header_byte(cfg_i, {word_addr_i, 1'b1}),
              header_byte(cfg_i, {word_addr_i, 1'b0})};
  end

endmodule

// File: rtl/config_uploader.sv
// Serves ioctl upload reads: low word addresses from a snapshot of the config
// header, higher addresses from external memory over a req/ack handshake.
module config_uploader
  import gw_config_pkg::*;
#(
  parameter logic [24:0] HEADER_WORDS = 25'h80,
  parameter logic [23:0] MEM_WORDS    = 24'h4000,
  parameter logic [7:0]  MEM_TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  input  logic [7:0]  mpu,
  input  logic [7:0]  screen_config,
  input  logic [11:0] screen_width,
  input  logic [11:0] screen_height,
  input  logic [31:0] input_s0_config,
  input  logic [31:0] input_s1_config,
  input  logic [31:0] input_s2_config,
  input  logic [31:0] input_s3_config,
  input  logic [31:0] input_s4_config,
  input  logic [31:0] input_s5_config,
  input  logic [31:0] input_s6_config,
  input  logic [31:0] input_s7_config,
  input  logic [7:0]  input_b_config,
  input  logic [7:0]  input_ba_config,
  input  logic [7:0]  input_acl_config,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        timeout_err,
  output logic [1:0]  fsm_state
);

  // Memory handshake: mem_rd rises with mem_addr valid and stays high until
  // the cycle mem_ack is sampled (or the read is aborted); mem_ack is a
  // one-cycle data-valid pulse and is ignored outside MEM_WAIT.

  upload_state_e state_q, state_d;
  game_config_t  cfg_q, cfg_d, live_cfg;
  logic          upload_q;
  logic          upload_rise;
  logic [15:0]   din_q, din_d;
  logic          wait_q, wait_d;
  logic          mem_rd_q, mem_rd_d;
  logic [23:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
  logic [24:0]   mem_offset;
  logic [15:0]   rom_word;

  always_comb begin
    live_cfg = '{
      mpu:           mpu,
      screen_config: screen_config,
      screen_width:  screen_width,
      screen_height: screen_height,
      input_s:       {input_s7_config, input_s6_config, input_s5_config, input_s4_config,
                      input_s3_config, input_s2_config, input_s1_config, input_s0_config},
      input_b:       input_b_config,
      input_ba:      input_ba_config,
      input_acl:     input_acl_config
    };
  end

  assign upload_rise = ioctl_upload & ~upload_q;
  assign mem_offset  = ioctl_addr - HEADER_WORDS;

  config_header_rom u_rom (
    .cfg_i       (cfg_q),
    .word_addr_i (ioctl_addr[6:0]),
    .word_o      (rom_word)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    din_d      = din_q;
    wait_d     = wait_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;

    if (upload_rise) begin
      cfg_d = live_cfg;
      err_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ioctl_rd && ioctl_upload) begin
          if (ioctl_addr < HEADER_WORDS) begin
            din_d   = rom_word;
            state_d = ST_HDR;
          // Range check uses the full 25-bit offset so huge addresses cannot alias into memory.
          end else if (mem_offset >= {1'b0, MEM_WORDS}) begin
            din_d   = 16'h0000;
            state_d = ST_HDR;
          end else begin
            mem_addr_d = mem_offset[23:0];
            mem_rd_d   = 1'b1;
            wait_d     = 1'b1;
            tmo_cnt_d  = 8'd0;
            state_d    = ST_MEM_WAIT;
          end
        end
      end
      ST_HDR: begin
        state_d = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (!ioctl_upload) begin
          mem_rd_d = 1'b0;
          wait_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (mem_ack) begin
          din_d    = mem_data;
          mem_rd_d = 1'b0;
          wait_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (tmo_cnt_d == MEM_TIMEOUT) begin
          din_d    = TIMEOUT_WORD;
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
          wait_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      upload_q   <= 1'b0;
      din_q      <= 16'h0000;
      wait_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 24'h000000;
      tmo_cnt_q  <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      upload_q   <= ioctl_upload;
      din_q      <= din_d;
      wait_q     <= wait_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
    end
  end

  assign ioctl_din   = din_q;
  assign ioctl_wait  = wait_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign timeout_err = err_q;
  assign fsm_state   = state_q;

endmodule

// File: doc/config_uploader.md
Name: config_uploader

Overview:
- Upload-direction counterpart of the cartridge download path.
- Serves host `ioctl` read requests during an upload.
- Word addresses 0x00–0x7F: a 16-bit-word image of the game config header, in the same byte layout the loader parses.
- Word addresses from 0x80: words fetched from an external memory through a req/ack handshake.
- Sits between the HPS `ioctl` bus and the core's config registers / save RAM.

Parameters:
- HEADER_WORDS, 25'h80, first word address that is served from memory rather than the header.
- MEM_WORDS, 24'h4000, number of valid memory words; reads at or beyond this return 0 with no memory access.
- MEM_TIMEOUT, 8'd255, maximum cycles to wait for `mem_ack` before aborting the read.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ioctl_upload  in  1  high for the whole upload session
- ioctl_rd  in  1  one-cycle read strobe
- ioctl_addr  in  25  word address
- ioctl_din  out  16  read data to host
- ioctl_wait  out  1  stall; host holds off its next `ioctl_rd` while high
- mpu  in  8  config value
- screen_config  in  8  config value
- screen_width  in  12  config value
- screen_height  in  12  config value
- input_s0_config..input_s7_config  in  32 each  config values
- input_b_config, input_ba_config, input_acl_config  in  8 each  config values
- mem_addr  out  24  memory word address
- mem_rd  out  1  memory read request
- mem_ack  in  1  one-cycle data-valid
- mem_data  in  16  memory read data
- timeout_err  out  1  sticky; set on memory timeout

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; snapshot registers 0.
  - Reset mid-transaction aborts immediately; a later `mem_ack` is ignored.
- Snapshot:
  - On the rising edge of `ioctl_upload` (registered edge detect), all config inputs are captured.
  - Header reads use only the snapshot.
- Header byte image (byte k; word n = {byte 2n+1, byte 2n}):
  - byte 0: 8'h01 (version)
  - byte 1: mpu
  - byte 2: screen_config
  - bytes 3–5: {screen_height, screen_width}, LSB first
  - bytes 6–7: 0
  - bytes 8–39: s0..s7, each LSB first
  - byte 40: b; byte 41: ba; byte 42: acl
  - bytes 43–255: 0
- State machine: IDLE, HDR, MEM_WAIT.
  - **IDLE:**
    - `ioctl_rd` while `ioctl_upload`=1 latches the address.
    - addr < HEADER_WORDS -> HDR.
    - Otherwise compute mem offset = addr − HEADER_WORDS.
    - offset ≥ MEM_WORDS -> HDR path with data 0.
    - Else drive `mem_addr` = offset, `mem_rd`=1, `ioctl_wait`=1 -> MEM_WAIT.
    - `ioctl_rd` with `ioctl_upload`=0 is ignored.
  - **HDR:** `ioctl_din` is updated to the header word (or 0) exactly 1 cycle after `ioctl_rd`; `ioctl_wait` stays 0; -> IDLE.
  - **MEM_WAIT:**
    - `mem_rd` is held high until `mem_ack`.
    - On `mem_ack`: `ioctl_din` <= `mem_data`, `mem_rd`=0, `ioctl_wait`=0 on the next cycle; -> IDLE.
    - Timeout counter increments each cycle. If it reaches MEM_TIMEOUT: `ioctl_din` <= 16'hDEAD, `timeout_err`=1, `mem_rd`=0, `ioctl_wait`=0; -> IDLE.
- Boundaries:
  - `ioctl_rd` while not IDLE is ignored (protocol violation, no effect).
  - `ioctl_upload` falling in MEM_WAIT aborts: -> IDLE, `mem_rd`/`ioctl_wait` cleared, `ioctl_din` unchanged.
  - `mem_ack` in the same cycle the timeout fires: ack wins.
  - `timeout_err` clears only on reset or a new upload rising edge.
  - Address subtraction is 25-bit; the result is truncated to 24 bits.

Decomposition:
- Shared package `gw_config_pkg`:
  - header address constants (IMAGE_START_ADDR etc.)
  - header byte-offset localparams (VERSION_BYTE=0, MPU_BYTE=1, SCREEN_CFG_BYTE=2, SCREEN_SIZE_BYTE=3, INPUT_MAP_BYTE=8, INPUT_B_BYTE=40, …)
  - HEADER_VERSION=8'h01
  - typedef `game_config_t` struct bundling all config fields
- One sub-module, `config_header_rom`: combinational mux from `game_config_t` snapshot + word address [6:0] to a 16-bit word.
- The loader can later reuse the same struct and offsets.

Test Plan:
- Snapshot: mpu=8'h02, screen_config=8'h11, width=12'h2A0, height=12'h1E0; upload rising edge, then inputs changed. Read addr 0 -> din=16'h0201 after 1 cycle, wait never high. Addr 1 -> 16'hA011. Addr 2 -> 16'h1E02.
- Input map: s0=32'h04030201, acl=8'h77. Addr 4 -> 16'h0201; addr 5 -> 16'h0403; addr 21 -> 16'h0077; addr 0x7F -> 16'h0000.
- Memory read: addr 0x85 -> mem_addr=24'h5, mem_rd and wait high. Ack with 16'hBEEF after 3 cycles -> din=16'hBEEF, wait low the next cycle.
- Out of range: addr 0x80+MEM_WORDS -> din=0, mem_rd never asserted.
- Timeout: no ack -> after 255 cycles din=16'hDEAD, timeout_err=1. Next upload rising edge clears it.
- Aborts:
  - reset asserted in MEM_WAIT -> all outputs 0; a later ack has no effect.
  - `ioctl_upload` dropped in MEM_WAIT -> IDLE, mem_rd=0.
